// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: requester ids and default widths shared by the arbiter and the memory instance
package mem_arb_pkg;
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LSU = 1'b1;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 16;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: two-way one-hot winner select; MEM_ARB_ROUND_ROBIN_EN selects round-robin, else requester 0 has fixed priority
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);
`ifdef MEM_ARB_ROUND_ROBIN_EN
  // on conflict the requester that did not win last time goes first
  assign grant[0] = valid0 & (~valid1 | (last_grant == REQ_LSU));
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  // requester 0 always wins a conflict
  assign grant[0] = valid0;
`endif
  assign grant[1] = valid1 & ~grant[0];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch (0) and load/store (1); optional MEM_ARB_ROUND_ROBIN_EN
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_rvalid,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_rvalid,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);
  logic [1:0] grant;
  logic       rd_pend;
  logic       rd_owner;
  logic       last_grant;
  // reset masks both requests so nothing is granted while it is high
  mem_arb_pick u_pick (
    .valid0     (req0_valid & ~reset),
    .valid1     (req1_valid & ~reset),
    .last_grant (last_grant),
    .grant      (grant)
  );
  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign req0_rvalid = rd_pend & (rd_owner == REQ_FETCH);
  assign req1_rvalid = rd_pend & (rd_owner == REQ_LSU);
  assign req0_rdata  = mem_read_data;
  assign req1_rdata  = mem_read_data;
  // winner's command onto the memory port; idle is a read of address 0
  always_comb begin
    mem_address      = grant[0] ? req0_addr : grant[1] ? req1_addr : '0;
    mem_write_data   = grant[1] ? req1_wdata : req0_wdata;
    mem_write_enable = grant[0] ? req0_we : grant[1] & req1_we;
  end
  // read-response pipeline and last winner
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend    <= 1'b0;
      rd_owner   <= REQ_FETCH;
      last_grant <= REQ_LSU;
    end else begin
      rd_pend <= |grant & ~mem_write_enable;
      if (|grant & ~mem_write_enable) rd_owner <= grant[1];
      if (|grant) last_grant <= grant[1];
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port, 16-bit-wide synchronous `memory` block between the instruction-fetch path (requester 0) and the load/store path (requester 1). Each cycle it grants at most one request and drives the memory port with the winner's command. It returns read data to the correct requester one cycle later. It sits directly between the CPU core's fetch and load/store units and the `memory` instance.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: address width. It must match the memory instance.
- `DATA_WIDTH`, default 16: data width. It must match the memory instance.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `req0_valid`, input, 1: requester 0 has a command.
- `req0_we`, input, 1: 1 means write, 0 means read.
- `req0_addr`, input, ADDR_WIDTH: target address.
- `req0_wdata`, input, DATA_WIDTH: write data.
- `req0_ready`, output, 1: command accepted this cycle (grant).
- `req0_rvalid`, output, 1: read data for requester 0 is valid this cycle.
- `req0_rdata`, output, DATA_WIDTH: read data.
- `req1_*`: identical set of seven ports for requester 1.
- `mem_address`, output, ADDR_WIDTH: to the memory `address` input.
- `mem_write_data`, output, DATA_WIDTH: to the memory `write_data` input.
- `mem_write_enable`, output, 1: to the memory `write_enable` input.
- `mem_read_data`, input, DATA_WIDTH: from the memory `read_data` output.

## Operation
- **Handshake:** a command transfers on a cycle where `reqN_valid` and `reqN_ready` are both 1.
  - The requester holds `valid`, `we`, `addr` and `wdata` stable until `ready`.
  - `ready` is combinational from the `valid` inputs and the arbitration state.
- **Grant:**
  - If only one requester is valid, that requester is granted.
  - If both are valid, the priority policy decides (see Configuration).
  - If neither is valid, there is no grant.
- **Memory drive on a grant:** `mem_address`, `mem_write_data` and `mem_write_enable` take the winner's `addr`, `wdata` and `we`.
- **Memory drive with no grant:** `mem_write_enable` = 0 and `mem_address` = 0 (an idle read of address 0 is harmless).
- **Read tracking:** a granted read sets the registered flags `rd_pend` = 1 and `rd_owner` = N.
  - On the next cycle `reqN_rvalid` = 1 for that owner only.
  - Both `req0_rdata` and `req1_rdata` carry `mem_read_data` unconditionally. They are qualified only by `rvalid`.
- **Write completion:** writes produce no response. A write is complete at the accepting edge.
- **Throughput:** back-to-back grants are allowed every cycle, including read, write, read sequences.
  - The memory holds `read_data` during write cycles, so a read response is never corrupted by the write that follows it.
- **Read-after-write:** a write at cycle N followed by a read of the same address at cycle N+1 returns the new data.

## Timing
- **Reset values (after a cycle with `reset` = 1):**
  - `rd_pend` = 0, `rd_owner` = 0, `last_grant` = 1.
  - All `rvalid` outputs = 0.
  - While `reset` is high: both `ready` = 0 and `mem_write_enable` = 0.
- **Read latency:** the grant is at cycle N and `rvalid` is at cycle N+1. This is fixed, with no stalls.
- **Reset mid-operation:** a read granted in the cycle `reset` rises is dropped, and no `rvalid` follows.
- **Simultaneous events:** a read response for one requester and a new grant to the other in the same cycle is legal and required.
- **No request:** no grant, no change to `last_grant`, and no `rvalid` on the next cycle.

## Configuration
- Macro: `MEM_ARB_ROUND_ROBIN_EN`.
- **Defined (round-robin):**
  - On conflict, grant the requester not equal to `last_grant`.
  - `last_grant` updates on every grant.
  - Reset value 1 means requester 0 wins the first conflict.
- **Undefined (fixed priority):**
  - Requester 0 always wins conflicts.
  - `last_grant` is still maintained but not used.
  - Requester 1 can starve, and this is accepted.

## Structure
- **Shared package `mem_arb_pkg`:**
  - Constants `REQ_FETCH` = 0 and `REQ_LSU` = 1.
  - Default `ADDR_WIDTH` and `DATA_WIDTH` values, shared with the `memory` instantiation.
- **Sub-module `mem_arb_pick`:** combinational two-way winner select.
  - Inputs: `valid0`, `valid1`, `last_grant`.
  - Output: one-hot grant.
  - Policy is selected by the macro.
- **Top level:** command mux, `rd_pend` / `rd_owner` pipeline register, `last_grant` register.

## Test plan
- **Single read:** write `0x1234` to address 3 via requester 0, then read address 3 via requester 1 → `req1_rvalid` = 1 exactly one cycle after the grant, `req1_rdata` = `0x1234`, `req0_rvalid` stays 0.
- **Conflict, round-robin:** both requesters valid for 4 cycles reading addresses 0 and 1 → grant order 0, 1, 0, 1; each `rvalid` appears one cycle after its grant with correct data.
- **Conflict, fixed priority (macro undefined):** same stimulus → requester 0 granted all 4 cycles, `req1_ready` stays 0.
- **Read-after-write:** requester 1 writes `0xBEEF` to address 2 at cycle N, requester 0 reads address 2 at cycle N+1 → `req0_rdata` = `0xBEEF` at cycle N+2.
- **Reset mid-read:** read granted and `reset` asserted in the same cycle → no `rvalid` on any port the following cycle; all outputs at reset values.
- **Idle:** no `valid` for 5 cycles → `mem_write_enable` = 0, `mem_address` = 0, no `ready`, no `rvalid`.
